// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
//   Shared definitions for the fetch stage and the decode controller:
//   RV32I major opcode constants, the canonical NOP encoding
//   (addi x0,x0,0), and the fetch FSM state type.
// ----------------------------------------------------------------------------
package riscv_pkg;

   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   typedef enum logic [2:0] {
      S_BOOT,
      S_REQ,
      S_WAIT,
      S_HOLD,
      S_HALT
   } fetch_state_t;

endpackage

// File: rtl/ifu_next_pc.sv
// ----------------------------------------------------------------------------
// ifu_next_pc
//   Combinational next-PC logic for the fetch unit.
//   Build option: IFU_MISALIGN_TRAP_EN adds the 'misaligned' output.
//
//   pc         in   XLEN  address of the held instruction
//   pc_src     in   1     take the redirect target
//   pc_target  in   XLEN  redirect address from the controller
//   pc_plus4   out  XLEN  pc + 4, wraps modulo 2^XLEN
//   next_pc    out  XLEN  redirect (word aligned) or pc + 4
//   misaligned out  1     redirect requested to a non-word address
//                         (only with IFU_MISALIGN_TRAP_EN)
// ----------------------------------------------------------------------------
module ifu_next_pc
   import riscv_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic [XLEN-1:0] pc,
   input  logic            pc_src,
   input  logic [XLEN-1:0] pc_target,
   output logic [XLEN-1:0] pc_plus4,
   output logic [XLEN-1:0] next_pc
`ifdef IFU_MISALIGN_TRAP_EN
   ,
   output logic            misaligned
`endif
);

   assign pc_plus4 = pc + XLEN'(4);

   // The low two target bits are always dropped; when trapping is enabled
   // the caller blocks the redirect instead of using this value.
   always_comb begin
      next_pc = pc_plus4;
      if (pc_src) begin
         next_pc = pc_target & ~XLEN'(3);
      end
   end

`ifdef IFU_MISALIGN_TRAP_EN
   assign misaligned = pc_src && (pc_target[1:0] != 2'b00);
`endif

endmodule

// File: rtl/instr_fetch_unit.sv
// ----------------------------------------------------------------------------
// instr_fetch_unit
//   Fetch stage: owns the PC, fetches one instruction at a time from IMEM
//   over a req/gnt/rvalid handshake, holds it for the decode controller and
//   advances the PC (sequential or redirected) when the instruction retires.
//   Build option: IFU_MISALIGN_TRAP_EN - a misaligned redirect halts fetch
//   and raises the sticky misalign_err output instead of being masked.
//
//   clk, rst_n    in   clock (rising edge), async active-low reset
//   imem_req      out  fetch request, held with imem_addr until imem_gnt
//   imem_addr     out  fetch address (= pc)
//   imem_gnt      in   request accepted
//   imem_rvalid   in   read data valid (honoured only while waiting)
//   imem_rdata    in   instruction word
//   instr_valid   out  instr/pc hold a valid fetched instruction
//   instr_ready   in   downstream retires the instruction this cycle
//   stall         in   global hold, blocks retire
//   pc_src        in   take pc_target on retire
//   pc_target     in   redirect address
//   instr         out  held instruction word
//   op/funct3/funct7 out  slices of instr
//   pc, pc_plus4  out  held instruction address and its link value
//   fetch_busy    out  request or response outstanding
//   misalign_err  out  sticky misaligned redirect flag (option only)
// ----------------------------------------------------------------------------
module instr_fetch_unit
   import riscv_pkg::*;
#(
   parameter int unsigned     XLEN     = 32,
   parameter logic [XLEN-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            rst_n,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_gnt,
   input  logic            imem_rvalid,
   input  logic [31:0]     imem_rdata,
   output logic            instr_valid,
   input  logic            instr_ready,
   input  logic            stall,
   input  logic            pc_src,
   input  logic [XLEN-1:0] pc_target,
   output logic [31:0]     instr,
   output logic [6:0]      op,
   output logic [2:0]      funct3,
   output logic            funct7,
   output logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_plus4,
   output logic            fetch_busy
`ifdef IFU_MISALIGN_TRAP_EN
   ,
   output logic            misalign_err
`endif
);

   fetch_state_t    state;
   fetch_state_t    state_next;
   logic [XLEN-1:0] pc_next;
   logic            capture;
   logic            retire;
   logic            advance;

`ifdef IFU_MISALIGN_TRAP_EN
   logic            misaligned;
`endif

   ifu_next_pc #(
      .XLEN (XLEN)
   ) u_next_pc (
      .pc         (pc),
      .pc_src     (pc_src),
      .pc_target  (pc_target),
      .pc_plus4   (pc_plus4),
      .next_pc    (pc_next)
`ifdef IFU_MISALIGN_TRAP_EN
      ,
      .misaligned (misaligned)
`endif
   );

   assign capture = (state == S_WAIT) && imem_rvalid;
   assign retire  = (state == S_HOLD) && instr_ready && !stall;

`ifdef IFU_MISALIGN_TRAP_EN
   assign advance = retire && !misaligned;
`else
   assign advance = retire;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= S_BOOT;
         pc    <= RESET_PC;
         instr <= NOP_INSTR;
`ifdef IFU_MISALIGN_TRAP_EN
         misalign_err <= 1'b0;
`endif
      end else begin
         state <= state_next;
         if (capture) begin
            instr <= imem_rdata;
         end
         if (advance) begin
            pc <= pc_next;
         end
`ifdef IFU_MISALIGN_TRAP_EN
         if (retire && misaligned) begin
            misalign_err <= 1'b1;
         end
`endif
      end
   end

   always_comb begin
      state_next  = state;
      imem_req    = 1'b0;
      fetch_busy  = 1'b0;
      instr_valid = 1'b0;
      case (state)
         S_BOOT: begin
            state_next = S_REQ;
         end
         S_REQ: begin
            imem_req   = 1'b1;
            fetch_busy = 1'b1;
            if (imem_gnt) begin
               state_next = S_WAIT;
            end
         end
         S_WAIT: begin
            fetch_busy = 1'b1;
            if (imem_rvalid) begin
               state_next = S_HOLD;
            end
         end
         S_HOLD: begin
            instr_valid = 1'b1;
            if (retire) begin
`ifdef IFU_MISALIGN_TRAP_EN
               state_next = misaligned ? S_HALT : S_REQ;
`else
               state_next = S_REQ;
`endif
            end
         end
         S_HALT: begin
            state_next = S_HALT;
         end
         default: begin
            state_next = S_BOOT;
         end
      endcase
   end

   assign imem_addr = pc;
   assign op        = instr[6:0];
   assign funct3    = instr[14:12];
   assign funct7    = instr[30];

endmodule
